// File: rtl/gpio_ctrl_if.sv
// Wishbone-style peripheral bus bundle for the GPIO controller.
// The master side drives the request; the slave side returns data and ack.
interface gpio_ctrl_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [4:0]  wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: output/enable registers, atomic set/clear,
// synchronised pad inputs and edge-detect interrupts with a W1C pending register.
// The pad tri-state itself lives outside: io_data[n] = en_gpio[n] ? o_gpio[n] : Z.
module gpio_ctrl #(
    parameter int NUM_GPIO    = 32,  // 1..32; register bits above this read 0
    parameter int SYNC_STAGES = 2    // input synchroniser depth, at least 2
) (
    input  logic                clk,
    input  logic                reset,
    gpio_ctrl_if.slave          bus,
    input  logic [NUM_GPIO-1:0] i_gpio,
    output logic [NUM_GPIO-1:0] o_gpio,
    output logic [NUM_GPIO-1:0] en_gpio,
    output logic                irq_o
);

    typedef enum logic [2:0] {
        REG_DIN  = 3'd0,
        REG_DOUT = 3'd1,
        REG_OE   = 3'd2,
        REG_SET  = 3'd3,
        REG_CLR  = 3'd4,
        REG_RISE = 3'd5,
        REG_FALL = 3'd6,
        REG_PEND = 3'd7
    } reg_sel_e;

    // State
    logic [NUM_GPIO-1:0] out_reg, oe_reg, rise_en_reg, fall_en_reg, pend_reg;
    logic [NUM_GPIO-1:0] sync_reg [SYNC_STAGES];
    logic [NUM_GPIO-1:0] prev_reg;
    logic                ack_reg;
    logic [31:0]         dat_reg;
    logic                irq_reg;

    // Next-state / decode
    logic [NUM_GPIO-1:0] out_next, oe_next, rise_en_next, fall_en_next, pend_next;
    logic [NUM_GPIO-1:0] w1c, rise_det, fall_det, s_in, mask_n, wdat_n;
    logic [31:0]         byte_mask, wdat_m, rd_mux;
    logic [31:0]         din_w, dout_w, oe_w, rise_w, fall_w, pend_w;
    logic                req;
    reg_sel_e            reg_sel;

    // Address bits [1:0] are byte offsets within a word and carry no meaning here.
    logic unused_adr_bits;
    assign unused_adr_bits = ^bus.wb_adr_i[1:0];

    // A new request is only taken while ack is low, so accesses are spaced by 2 cycles.
    assign req     = bus.wb_cyc_i & bus.wb_stb_i & ~ack_reg;
    assign reg_sel = reg_sel_e'(bus.wb_adr_i[4:2]);

    // Expand the four byte enables into a per-bit write mask.
    for (genvar gi = 0; gi < 32; gi++) begin : g_mask
        assign byte_mask[gi] = bus.wb_sel_i[gi/8];
    end

    // Unselected bytes behave as zero data, which also makes SET/CLR/W1C byte-safe.
    assign wdat_m = bus.wb_dat_i & byte_mask;
    assign mask_n = byte_mask[NUM_GPIO-1:0];
    assign wdat_n = wdat_m[NUM_GPIO-1:0];

    // Zero-extend the NUM_GPIO-wide registers to the 32-bit read bus.
    for (genvar gi = 0; gi < 32; gi++) begin : g_pad
        if (gi < NUM_GPIO) begin : g_live
            assign din_w[gi]  = s_in[gi];
            assign dout_w[gi] = out_reg[gi];
            assign oe_w[gi]   = oe_reg[gi];
            assign rise_w[gi] = rise_en_reg[gi];
            assign fall_w[gi] = fall_en_reg[gi];
            assign pend_w[gi] = pend_reg[gi];
        end else begin : g_zero
            assign din_w[gi]  = 1'b0;
            assign dout_w[gi] = 1'b0;
            assign oe_w[gi]   = 1'b0;
            assign rise_w[gi] = 1'b0;
            assign fall_w[gi] = 1'b0;
            assign pend_w[gi] = 1'b0;
        end
    end

    // Edge detection on the synchronised input against last cycle's sample.
    assign s_in     = sync_reg[SYNC_STAGES-1];
    assign rise_det = s_in & ~prev_reg;
    assign fall_det = ~s_in & prev_reg;

    // Register write decode and pending update; a fresh edge beats a same-cycle W1C.
    always_comb begin
        out_next     = out_reg;
        oe_next      = oe_reg;
        rise_en_next = rise_en_reg;
        fall_en_next = fall_en_reg;
        w1c          = '0;
        if (req && bus.wb_we_i) begin
            case (reg_sel)
                REG_DOUT: out_next     = (out_reg & ~mask_n) | wdat_n;
                REG_OE:   oe_next      = (oe_reg & ~mask_n) | wdat_n;
                REG_SET:  out_next     = out_reg | wdat_n;
                REG_CLR:  out_next     = out_reg & ~wdat_n;
                REG_RISE: rise_en_next = (rise_en_reg & ~mask_n) | wdat_n;
                REG_FALL: fall_en_next = (fall_en_reg & ~mask_n) | wdat_n;
                REG_PEND: w1c          = wdat_n;
                default:  ;
            endcase
        end
        pend_next = (pend_reg & ~w1c) | (rise_det & rise_en_reg) | (fall_det & fall_en_reg);
    end

    // Read data selection; SET and CLR are write-only and read as zero.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_DIN:  rd_mux = din_w;
            REG_DOUT: rd_mux = dout_w;
            REG_OE:   rd_mux = oe_w;
            REG_RISE: rd_mux = rise_w;
            REG_FALL: rd_mux = fall_w;
            REG_PEND: rd_mux = pend_w;
            default:  rd_mux = '0;
        endcase
    end

    // Input synchroniser chain plus the previous-sample register for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_reg[k] <= '0;
            prev_reg <= '0;
        end else begin
            sync_reg[0] <= i_gpio;
            for (int k = 1; k < SYNC_STAGES; k++) sync_reg[k] <= sync_reg[k-1];
            prev_reg <= s_in;
        end
    end

    // Bus handshake and register file; writes land on the same edge that raises ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg     <= '0;
            oe_reg      <= '0;
            rise_en_reg <= '0;
            fall_en_reg <= '0;
            pend_reg    <= '0;
            ack_reg     <= 1'b0;
            dat_reg     <= '0;
        end else begin
            out_reg     <= out_next;
            oe_reg      <= oe_next;
            rise_en_reg <= rise_en_next;
            fall_en_reg <= fall_en_next;
            pend_reg    <= pend_next;
            ack_reg     <= req;
            if (req && !bus.wb_we_i) dat_reg <= rd_mux;
        end
    end

    // Interrupt registered from the next pending value so it tracks pend with no extra lag.
    always_ff @(posedge clk) begin
        if (reset) irq_reg <= 1'b0;
        else       irq_reg <= |(pend_next & (rise_en_reg | fall_en_reg));
    end

    assign o_gpio       = out_reg;
    assign en_gpio      = oe_reg;
    assign irq_o        = irq_reg;
    assign bus.wb_ack_o = ack_reg;
    assign bus.wb_dat_o = dat_reg;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed scenarios with literal expectations,
// then randomized bus/pin traffic checked every cycle against a behavioural model.
module tb_gpio_ctrl;
    localparam int N = 32;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] i_gpio;
    logic [N-1:0] o_gpio;
    logic [N-1:0] en_gpio;
    logic         irq_o;

    gpio_ctrl_if bus();

    gpio_ctrl #(.NUM_GPIO(N), .SYNC_STAGES(S)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .i_gpio (i_gpio),
        .o_gpio (o_gpio),
        .en_gpio(en_gpio),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pin history replaces the flop chain: DIN at an edge is the pin value sampled
    // S edges earlier, and the previous sample is one edge older still.
    bit          m_valid = 0;
    logic [31:0] m_out, m_oe, m_rise, m_fall, m_pend, m_dat;
    logic        m_ack, m_irq;
    logic [31:0] m_hist [0:S];
    logic [31:0] m_s, m_p, m_mask, m_d, m_edge_r, m_edge_f, m_w1c, m_pn;
    logic        m_req;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1;
            m_out = 0; m_oe = 0; m_rise = 0; m_fall = 0; m_pend = 0; m_dat = 0;
            m_ack = 0; m_irq = 0;
            for (int j = 0; j <= S; j++) m_hist[j] = 0;
        end else if (m_valid) begin
            m_s   = m_hist[S-1];
            m_p   = m_hist[S];
            m_req = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
            for (int b = 0; b < 4; b++) m_mask[b*8 +: 8] = {8{bus.wb_sel_i[b]}};
            m_d      = bus.wb_dat_i & m_mask;
            m_edge_r = m_s & ~m_p;
            m_edge_f = ~m_s & m_p;
            m_w1c    = (m_req && bus.wb_we_i && bus.wb_adr_i[4:2] == 3'd7) ? m_d : 32'h0;
            m_pn     = (m_pend & ~m_w1c) | (m_edge_r & m_rise) | (m_edge_f & m_fall);
            m_irq    = |(m_pn & (m_rise | m_fall));
            if (m_req && !bus.wb_we_i) begin
                case (bus.wb_adr_i[4:2])
                    3'd0: m_dat = m_s;
                    3'd1: m_dat = m_out;
                    3'd2: m_dat = m_oe;
                    3'd5: m_dat = m_rise;
                    3'd6: m_dat = m_fall;
                    3'd7: m_dat = m_pend;
                    default: m_dat = 0;
                endcase
            end
            if (m_req && bus.wb_we_i) begin
                case (bus.wb_adr_i[4:2])
                    3'd1: m_out  = (m_out & ~m_mask) | m_d;
                    3'd2: m_oe   = (m_oe & ~m_mask) | m_d;
                    3'd3: m_out  = m_out | m_d;
                    3'd4: m_out  = m_out & ~m_d;
                    3'd5: m_rise = (m_rise & ~m_mask) | m_d;
                    3'd6: m_fall = (m_fall & ~m_mask) | m_d;
                    default: ;
                endcase
            end
            m_pend = m_pn;
            m_ack  = m_req;
            for (int j = S; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = i_gpio;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_ack",  {31'h0, bus.wb_ack_o}, {31'h0, m_ack});
            chk("cyc_dat",  bus.wb_dat_o, m_dat);
            chk("cyc_out",  o_gpio, m_out);
            chk("cyc_oe",   en_gpio, m_oe);
            chk("cyc_irq",  {31'h0, irq_o}, {31'h0, m_irq});
        end
    end

    // ---------------- bus tasks ----------------
    task automatic bus_idle();
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        bus.wb_adr_i = 0; bus.wb_sel_i = 0; bus.wb_dat_i = 0;
    endtask

    // Holds stb through the ack cycle to show ack drops even with stb still high.
    task automatic xfer(input bit w, input logic [4:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd);
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = w;
        bus.wb_adr_i = a; bus.wb_sel_i = s; bus.wb_dat_i = d;
        @(posedge clk); #1;
        chk("ack_high", {31'h0, bus.wb_ack_o}, 32'h1);
        rd = bus.wb_dat_o;
        @(posedge clk); #1;
        chk("ack_low", {31'h0, bus.wb_ack_o}, 32'h0);
        bus_idle();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        xfer(1'b1, a, s, d, dummy);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] v;
        xfer(1'b0, a, 4'hF, 32'h0, v);
        chk(name, v, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset  = 1;
        i_gpio = '0;
        bus_idle();
        wait_cyc(3);
        reset = 0;

        // 1. reset state and ack timing
        for (int r = 0; r < 8; r++) rd_chk("reset_read", 5'(r * 4), 32'h0);
        chk("reset_oe",  en_gpio, 32'h0);
        chk("reset_out", o_gpio, 32'h0);
        chk("reset_irq", {31'h0, irq_o}, 32'h0);

        // 2. output path
        wr(5'h08, 32'hFFFF_FFFF, 4'hF);
        wr(5'h04, 32'h5A5A_5A5A, 4'hF);
        chk("io_drive", o_gpio & en_gpio, 32'h5A5A_5A5A);
        wr(5'h0C, 32'h0000_000F, 4'hF);
        chk("set", o_gpio, 32'h5A5A_5A5F);
        wr(5'h10, 32'hF000_0000, 4'hF);
        chk("clr", o_gpio, 32'h0A5A_5A5F);
        wr(5'h04, 32'hFFFF_FFFF, 4'b0001);
        chk("dout_bytemask", o_gpio, 32'h0A5A_5AFF);
        rd_chk("set_reads0", 5'h0C, 32'h0);
        wr(5'h00, 32'h1234_5678, 4'hF);
        rd_chk("din_ro", 5'h00, 32'h0);

        // 3. input synchroniser latency
        wr(5'h08, 32'h0, 4'hF);
        i_gpio = 32'hA5A5_A5A5;
        wait_cyc(1);
        rd_chk("din_old", 5'h00, 32'h0);
        rd_chk("din_new", 5'h00, 32'hA5A5_A5A5);

        // 4. edge interrupts
        i_gpio = 32'h2;
        wait_cyc(5);
        wr(5'h14, 32'h1, 4'hF);
        wr(5'h18, 32'h2, 4'hF);
        rd_chk("pend_idle", 5'h1C, 32'h0);
        i_gpio = 32'h3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("irq_latency", {31'h0, irq_o}, (i == 3) ? 32'h1 : 32'h0);
        end
        @(posedge clk); #1;
        rd_chk("pend_rise", 5'h1C, 32'h1);
        i_gpio = 32'h1;
        wait_cyc(4);
        rd_chk("pend_fall", 5'h1C, 32'h3);
        wr(5'h1C, 32'h1, 4'hF);
        rd_chk("pend_w1c0", 5'h1C, 32'h2);
        chk("irq_held", {31'h0, irq_o}, 32'h1);
        wr(5'h1C, 32'h2, 4'hF);
        chk("irq_clear", {31'h0, irq_o}, 32'h0);
        rd_chk("pend_empty", 5'h1C, 32'h0);

        // 5. W1C colliding with a fresh edge on the same bit
        i_gpio = 32'h0;
        wait_cyc(5);
        i_gpio = 32'h1;
        wait_cyc(5);
        rd_chk("pend_pre", 5'h1C, 32'h1);
        i_gpio = 32'h0;
        wait_cyc(5);
        i_gpio = 32'h1;
        wait_cyc(2);
        wr(5'h1C, 32'h1, 4'hF);
        rd_chk("pend_edge_wins", 5'h1C, 32'h1);
        wr(5'h1C, 32'h1, 4'hF);
        rd_chk("pend_w1c_only", 5'h1C, 32'h0);

        // 6. reset in the middle of a transfer
        wr(5'h08, 32'h0000_FFFF, 4'hF);
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1;
        bus.wb_adr_i = 5'h04; bus.wb_sel_i = 4'hF; bus.wb_dat_i = 32'hFFFF_0000;
        wait_cyc(1);
        reset = 1;
        wait_cyc(1);
        chk("rst_mid_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        chk("rst_mid_out", o_gpio, 32'h0);
        chk("rst_mid_oe",  en_gpio, 32'h0);
        bus_idle();
        wait_cyc(1);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(1);
            chk("rst_no_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        end

        // 7. randomized traffic; the per-cycle compare does the checking
        repeat (3000) begin
            reset        = ($urandom_range(0, 299) == 0);
            bus.wb_cyc_i = ($urandom_range(0, 3) != 0);
            bus.wb_stb_i = $urandom_range(0, 1);
            bus.wb_we_i  = $urandom_range(0, 1);
            bus.wb_adr_i = 5'($urandom);
            bus.wb_sel_i = 4'($urandom);
            bus.wb_dat_i = $urandom;
            if ($urandom_range(0, 3) == 0) i_gpio = i_gpio ^ ($urandom & $urandom);
            wait_cyc(1);
        end
        reset = 0;
        bus_idle();
        wait_cyc(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
